uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, RX FIFO entries, power of two, legal 2..256.
REQ-003 SHALL have ports clk  in  1  sole clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en_i  in  1  receiver enable.
REQ-005 SHALL have port stop_bits_i  in  1  0 = 1 stop bit, 1 = 2 stop bits.
REQ-006 SHALL have port parity_bit_i  in  1  parity bit present.
REQ-007 SHALL have port parity_odd_i  in  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port baud_div_i  in  16  clk cycles per bit period.
REQ-009 SHALL have port rxd_i  in  1  asynchronous serial line, idle high.
REQ-010 SHALL have port rx_data_o  out  DATA_W  FIFO head data.
REQ-011 SHALL have port rx_valid_o  out  1  FIFO head valid.
REQ-012 SHALL have port rx_ready_i  in  1  consumer accepts the head entry.
REQ-013 SHALL have ports rx_parity_err_o and rx_frame_err_o  out  1 each  error flags of the head entry.
REQ-014 SHALL have port overrun_o  out  1  sticky overrun flag.
REQ-015 SHALL have port err_clr_i  in  1  clears overrun_o.
REQ-016 SHALL have port fifo_level_o  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
REQ-017 SHALL have port busy_o  out  1  frame reception in progress (FSM not IDLE).

Function
REQ-018 SHALL pass rxd_i through a 2-flop synchronizer; flops reset to 1; all detection uses the synchronized value.
REQ-019 SHALL run FSM states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-020 IDLE->START on a synchronized 1->0 transition while en_i=1; baud_div_i, stop_bits_i, parity_bit_i and parity_odd_i are latched at this transition and held for the frame.
REQ-021 SHALL use an effective divisor of max(latched baud_div, 4).
REQ-022 START samples the line floor(div/2) cycles after detection; 0 -> DATA; 1 -> false start, IDLE, nothing pushed.
REQ-023 DATA samples DATA_W bits LSB first, one every div cycles after the start sample; the next state is PARITY if parity is enabled, else STOP1.
REQ-024 PARITY samples one bit; parity error when XOR(data bits, parity bit) != parity_odd.
REQ-025 STOP1 (and STOP2 when 2 stop bits) samples the line; any 0 sets the frame error for that frame; a 2-stop-bit frame is pushed only after the STOP2 sample.
REQ-026 SHALL push {data, parity_err, frame_err} into the FIFO one cycle after the final stop sample; the FSM returns to IDLE on that cycle and may detect a new start edge on the next cycle.
REQ-027 FIFO is first-word fall-through: rx_valid_o = (level != 0); the entry pops on a cycle with rx_valid_o && rx_ready_i.
REQ-028 SHALL accept a push to a full FIFO when a pop occurs in the same cycle; the level is unchanged and overrun_o does not set.
REQ-029 A push to a full FIFO without a simultaneous pop SHALL drop the frame and set overrun_o; the FIFO contents stay unchanged.
REQ-030 overrun_o SHALL clear on err_clr_i=1; if a set and a clear occur in the same cycle, the set wins.
REQ-031 SHALL apply the rule en_i=0 -> the FSM aborts to IDLE the next cycle; the partial frame is discarded and the FIFO is retained.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-033 On rst_n=0: FSM=IDLE, counters=0, FIFO empty, rx_valid_o=0, fifo_level_o=0, rx_data_o=0, rx_parity_err_o=0, rx_frame_err_o=0, overrun_o=0, busy_o=0.
REQ-034 Reset mid-frame SHALL discard the frame with no push after release; the next frame requires a fresh start edge.

Configuration
REQ-035 UART_RX_PARITY_EN defined: parity_bit_i and parity_odd_i are honoured per REQ-023 and REQ-024.
REQ-036 UART_RX_PARITY_EN undefined: parity_bit_i and parity_odd_i are ignored, the PARITY state is never entered, and rx_parity_err_o=0 always.

Verification
REQ-037 baud_div=16, 8N1, 0xA5 -> one entry 0xA5, both errors 0, rx_valid_o rises 1 cycle after the stop sample.
REQ-038 UART_RX_PARITY_EN, even parity, 0xA5 with parity bit 1 -> entry 0xA5, rx_parity_err_o=1.
REQ-039 8N2, 0x3C with second stop bit 0 -> entry 0x3C, rx_frame_err_o=1.
REQ-040 Low glitch of 5 cycles at baud_div=16 -> false start, level stays 0, busy_o back to 0.
REQ-041 FIFO_DEPTH=4, rx_ready_i=0, frames 0x01..0x05 -> level 4, overrun_o=1, head 0x01; err_clr_i pulse -> overrun_o=0.
REQ-042 en_i dropped mid-DATA, then 0x5A sent -> only 0x5A stored; rst_n pulse mid-frame -> level 0, no push.

Source files
------------

// File: rtl/uart_rx_if.sv
// Consumer-side handshake bundle of the UART receiver FIFO.
// The receiver drives the head entry through the master modport; the consumer uses the slave modport.
interface uart_rx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              rx_ready_i;
  logic              rx_parity_err_o;
  logic              rx_frame_err_o;

  modport master (
    output rx_data_o,
    output rx_valid_o,
    output rx_parity_err_o,
    output rx_frame_err_o,
    input  rx_ready_i
  );

  modport slave (
    input  rx_data_o,
    input  rx_valid_o,
    input  rx_parity_err_o,
    input  rx_frame_err_o,
    output rx_ready_i
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with a first-word fall-through RX FIFO and a sticky overrun flag.
// Optional parity support is compiled in with UART_RX_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for a synchronized falling edge on the line
// START  | half a bit period in, confirming the start bit
// DATA   | sampling DATA_W data bits, LSB first
// PARITY | sampling the parity bit
// STOP1  | sampling the first stop bit
// STOP2  | sampling the second stop bit
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en_i,
  input  logic                                stop_bits_i,
  input  logic                                parity_bit_i,
  input  logic                                parity_odd_i,
  input  logic [15:0]                         baud_div_i,
  input  logic                                rxd_i,
  uart_rx_if.master                           rx,
  output logic                                overrun_o,
  input  logic                                err_clr_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level_o,
  output logic                                busy_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = DATA_W + 2;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [3:0]       BIT_LAST = 4'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t              state, state_n;
  logic                rxd_s1, rxd_s2, rxd_prev;
  logic [15:0]         cnt, cnt_n, div_q, div_n, eff_div;
  logic [3:0]          bit_cnt, bit_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic                two_stop_q, two_stop_n;
  logic                par_en_q, par_en_n, par_odd_q, par_odd_n;
  logic                par_err_q, par_err_n, frm_err_q, frm_err_n;
  logic                push_q, push_n;
  logic                par_en_cfg, par_odd_cfg;
  logic                sample;

`ifdef UART_RX_PARITY_EN
  assign par_en_cfg  = parity_bit_i;
  assign par_odd_cfg = parity_odd_i;
`else
  logic unused_par_cfg;
  assign unused_par_cfg = parity_bit_i ^ parity_odd_i;
  assign par_en_cfg     = 1'b0;
  assign par_odd_cfg    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_s1   <= rxd_i;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
    end
  end

  assign eff_div = (baud_div_i < 16'd4) ? 16'd4 : baud_div_i;
  assign sample  = (cnt == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      div_q      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      two_stop_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      push_q     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      div_q      <= div_n;
      bit_cnt    <= bit_n;
      shreg      <= shreg_n;
      two_stop_q <= two_stop_n;
      par_en_q   <= par_en_n;
      par_odd_q  <= par_odd_n;
      par_err_q  <= par_err_n;
      frm_err_q  <= frm_err_n;
      push_q     <= push_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    div_n      = div_q;
    bit_n      = bit_cnt;
    shreg_n    = shreg;
    two_stop_n = two_stop_q;
    par_en_n   = par_en_q;
    par_odd_n  = par_odd_q;
    par_err_n  = par_err_q;
    frm_err_n  = frm_err_q;
    push_n     = 1'b0;
    if (state != IDLE && !sample)
      cnt_n = cnt - 16'd1;
    case (state)
      IDLE: begin
        if (en_i && rxd_prev && !rxd_s2) begin
          state_n    = START;
          div_n      = eff_div;
          cnt_n      = {1'b0, eff_div[15:1]} - 16'd1;
          two_stop_n = stop_bits_i;
          par_en_n   = par_en_cfg;
          par_odd_n  = par_odd_cfg;
          par_err_n  = 1'b0;
          frm_err_n  = 1'b0;
        end
      end
      START: begin
        if (sample) begin
          if (!rxd_s2) begin
            state_n = DATA;
            cnt_n   = div_q - 16'd1;
            bit_n   = 4'd0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shreg_n = {rxd_s2, shreg[DATA_W-1:1]};
          cnt_n   = div_q - 16'd1;
          bit_n   = bit_cnt + 4'd1;
          if (bit_cnt == BIT_LAST)
            state_n = par_en_q ? PARITY : STOP1;
        end
      end
      PARITY: begin
        if (sample) begin
          par_err_n = ((^shreg) ^ rxd_s2) != par_odd_q;
          cnt_n     = div_q - 16'd1;
          state_n   = STOP1;
        end
      end
      STOP1: begin
        if (sample) begin
          frm_err_n = frm_err_q | ~rxd_s2;
          cnt_n     = div_q - 16'd1;
          if (two_stop_q) begin
            state_n = STOP2;
          end else begin
            state_n = IDLE;
            push_n  = 1'b1;
          end
        end
      end
      STOP2: begin
        if (sample) begin
          frm_err_n = frm_err_q | ~rxd_s2;
          state_n   = IDLE;
          push_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Disabling mid-frame throws the partial frame away, including a final stop sample.
    if (!en_i && state != IDLE) begin
      state_n = IDLE;
      push_n  = 1'b0;
    end
  end

  assign busy_o = (state != IDLE);

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [ENT_W-1:0] head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             full, valid, pop, push_ok, ovf;

  assign full    = (level == FULL_LVL);
  assign valid   = (level != '0);
  assign pop     = valid && rx.rx_ready_i;
  assign push_ok = push_q && (!full || pop);
  assign ovf     = push_q && full && !pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= {shreg, par_err_q, frm_err_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (ovf)
        overrun_o <= 1'b1;
      else if (err_clr_i)
        overrun_o <= 1'b0;
    end
  end

  // Outputs are gated so stale, unreset storage never shows while the FIFO is empty.
  assign fifo_level_o       = level;
  assign rx.rx_valid_o      = valid;
  assign rx.rx_data_o       = valid ? head[ENT_W-1:2] : '0;
  assign rx.rx_parity_err_o = valid & head[1];
  assign rx.rx_frame_err_o  = valid & head[0];

endmodule
